// File: rtl/adc_pkg.sv
// Shared ADC constants and SPI mode encodings.
// Imported by the averager and the SPI interface.
package adc_pkg;
  localparam int ADC_BITS = 12;
  localparam int NUM_CH   = 8;
  localparam int CH_BITS  = 3;

  typedef enum logic [2:0] {
    IDLE,
    SINGLE,
    CONTINUOUS,
    SINGLE_CONT,
    CONT_ONESHOT
  } adc_mode_e;
endpackage

// File: rtl/adc_chan_acc.sv
// One channel of the decimating averager:
// running sum, sample count, latest average and sticky alarm.
module adc_chan_acc
  import adc_pkg::*;
#(
  parameter int LOG2_AVG = 4,
  parameter int THRESH_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hit,
  input  logic [ADC_BITS-1:0] data,
  input  logic                clear,
  input  logic [THRESH_W-1:0] threshold,
  output logic                term,
  output logic [ADC_BITS-1:0] avg,
  output logic [ADC_BITS-1:0] result,
  output logic                alarm
);
  localparam int ACC_W = ADC_BITS + LOG2_AVG;
  localparam int CNT_W = (LOG2_AVG == 0) ? 1 : LOG2_AVG;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'((1 << LOG2_AVG) - 1);
  // Half an LSB of the output, zero when no averaging.
  localparam logic [ACC_W-1:0] RND =
    ACC_W'((1 << LOG2_AVG) >> 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] sum_r;

  assign sum   = acc + ACC_W'(data);
  assign sum_r = sum + RND;
  assign avg   = ADC_BITS'(sum_r >> LOG2_AVG);
  assign term  = hit && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      alarm  <= 1'b0;
    end else if (clear) begin
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      alarm  <= 1'b0;
    end else if (term) begin
      acc    <= '0;
      cnt    <= '0;
      result <= avg;
      if (avg > threshold)
        alarm <= 1'b1;
    end else if (hit) begin
      acc <= sum;
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/adc_channel_averager.sv
// Per-channel decimating averager behind the ADC SPI interface.
// Emits one rounded average per 2^LOG2_AVG samples of each channel.
module adc_channel_averager
  import adc_pkg::*;
#(
  parameter int LOG2_AVG = 4,
  parameter int THRESH_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [ADC_BITS-1:0] sample_data,
  input  logic [CH_BITS-1:0]  sample_chan,
  input  logic                clear,
  input  logic [THRESH_W-1:0] threshold,
  output logic                avg_valid,
  output logic [ADC_BITS-1:0] avg_data,
  output logic [CH_BITS-1:0]  avg_chan,
  input  logic [CH_BITS-1:0]  rd_chan,
  output logic [ADC_BITS-1:0] rd_avg,
  output logic [NUM_CH-1:0]   alarm
);
  logic [NUM_CH-1:0]   hit;
  logic [NUM_CH-1:0]   term;
  logic [ADC_BITS-1:0] avg_ch [NUM_CH];
  logic [ADC_BITS-1:0] res_ch [NUM_CH];
  logic [ADC_BITS-1:0] avg_n;
  logic [CH_BITS-1:0]  chan_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign hit[g] = sample_valid &&
                    (sample_chan == CH_BITS'(g));
    adc_chan_acc #(
      .LOG2_AVG (LOG2_AVG),
      .THRESH_W (THRESH_W)
    ) u_acc (
      .clk       (clk),
      .rst_n     (rst_n),
      .hit       (hit[g]),
      .data      (sample_data),
      .clear     (clear),
      .threshold (threshold),
      .term      (term[g]),
      .avg       (avg_ch[g]),
      .result    (res_ch[g]),
      .alarm     (alarm[g])
    );
  end

  // At most one channel terminates per cycle, so OR-ing is a one-hot mux.
  always_comb begin
    avg_n  = '0;
    chan_n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (term[i]) begin
        avg_n  = avg_n | avg_ch[i];
        chan_n = chan_n | CH_BITS'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_valid <= 1'b0;
      avg_data  <= '0;
      avg_chan  <= '0;
    end else if (clear) begin
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= |term;
      if (|term) begin
        avg_data <= avg_n;
        avg_chan <= chan_n;
      end
    end
  end

  assign rd_avg = res_ch[rd_chan];
endmodule
